// File: rtl/hs32_memresp_pkg.sv
// Shared constants, state encoding and request payload for hs32 bus memory responders.
package hs32_memresp_pkg;

  localparam int unsigned MR_ADDR_W = 32;
  localparam int unsigned MR_DATA_W = 32;
  localparam int unsigned MR_WAIT_W = 4;

  typedef enum logic [1:0] {
    MR_IDLE  = 2'd0,
    MR_WAITS = 2'd1,
    MR_ACC   = 2'd2,
    MR_DONE  = 2'd3
  } mr_state_e;

  typedef struct packed {
    logic [MR_ADDR_W-1:0] addr;
    logic [MR_DATA_W-1:0] dtw;
    logic                 rw;
  } mr_req_t;

  // Initial wait-counter load for a given wait-state count (0 means no WAITS phase).
  function automatic logic [MR_WAIT_W-1:0] mr_wait_init(input int unsigned waits);
    return (waits == 0) ? '0 : MR_WAIT_W'(waits - 1);
  endfunction

endpackage

// File: rtl/hs32_bram.sv
// Single-port synchronous word RAM, read-first, one-cycle registered read; maps to block RAM.
module hs32_bram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= din;
    end
    dout <= mem[adr];
  end

endmodule

// File: rtl/hs32_memresp.sv
// hs32 memory-interface responder: serves req/rdy accesses from an internal word RAM window
// with programmable wait states and a single registered rdy pulse per access.
module hs32_memresp
  import hs32_memresp_pkg::*;
#(
  parameter int unsigned          AW   = 10,
  parameter int unsigned          WAIT = 0,
  parameter logic [MR_ADDR_W-1:0] BASE = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MR_ADDR_W-1:0] addr,
  input  logic [MR_DATA_W-1:0] dtw,
  input  logic                 rw,
  input  logic                 req,
  output logic                 rdy,
  output logic [MR_DATA_W-1:0] dtr,
  output logic                 fault
);

  localparam int unsigned          WIN_W     = MR_ADDR_W + 1;
  localparam logic [WIN_W-1:0]     WIN_BYTES = WIN_W'(1) << (AW + 2);
  localparam logic [MR_WAIT_W-1:0] CNT_INIT  = mr_wait_init(WAIT);

  mr_state_e              state_q, state_d;
  logic [MR_WAIT_W-1:0]   cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  mr_req_t                req_q, req_d;
  logic                   rdy_d, fault_d;
  logic [MR_DATA_W-1:0]   dtr_d;
  logic [MR_ADDR_W-1:0]   offs_c;
  logic                   hit_c;
  logic                   ram_we_c;
  logic [MR_DATA_W-1:0]   ram_dout;

  // Window decode on the latched address; wraps below BASE fall outside via the unsigned compare.
  assign offs_c = req_q.addr - BASE;
  assign hit_c  = {1'b0, offs_c} < WIN_BYTES;

  hs32_bram #(
    .AW (AW),
    .DW (MR_DATA_W)
  ) u_bram (
    .clk  (clk),
    .we   (ram_we_c),
    .adr  (offs_c[AW+1:2]),
    .din  (req_q.dtw),
    .dout (ram_dout)
  );

  // Next-state and registered-output logic; ACC spans two cycles to cover the RAM read latency.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = 1'b0;
    req_d    = req_q;
    dtr_d    = dtr;
    rdy_d    = 1'b0;
    fault_d  = 1'b0;
    ram_we_c = 1'b0;

    unique case (state_q)
      MR_IDLE: begin
        if (req) begin
          req_d = '{addr: addr, dtw: dtw, rw: rw};
          if (WAIT != 0) begin
            state_d = MR_WAITS;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = MR_ACC;
          end
        end
      end
      MR_WAITS: begin
        if (!req) begin
          state_d = MR_IDLE;
        end else if (cnt_q == '0) begin
          state_d = MR_ACC;
        end else begin
          cnt_d = cnt_q - MR_WAIT_W'(1);
        end
      end
      MR_ACC: begin
        if (!pend_q) begin
          ram_we_c = req_q.rw && hit_c;
          pend_d   = 1'b1;
        end else begin
          if (!hit_c) begin
            dtr_d = '0;
          end else if (!req_q.rw) begin
            dtr_d = ram_dout;
          end
          rdy_d   = 1'b1;
          fault_d = !hit_c;
          state_d = MR_DONE;
        end
      end
      MR_DONE: begin
        state_d = MR_IDLE;
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MR_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      req_q   <= '0;
      rdy     <= 1'b0;
      fault   <= 1'b0;
      dtr     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      rdy     <= rdy_d;
      fault   <= fault_d;
      dtr     <= dtr_d;
    end
  end

endmodule
